// File: rtl/seg_scan_mux.sv
// Scan controller for a 4-digit common-anode 7-segment display.
// Double-buffered value/dp/enable, frame-aligned updates, leading-zero blanking.
module seg_scan_mux #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  en_in,
    input  logic        lzb,
    output logic [3:0]  nibble_out,
    output logic [3:0]  an,
    output logic        dp_n,
    output logic        frame_tick
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  en;
    } disp_t;

    logic [PW-1:0] presc, presc_nxt;
    logic [1:0]    idx, idx_nxt;
    disp_t         shadow, shadow_nxt, pending, pending_nxt, incoming;
    logic          pend_valid, pend_valid_nxt;
    logic          slot_wrap, boundary, lit;
    logic [3:0]    lz;
    logic [3:0]    nib_nxt, an_nxt;
    logic          dp_n_nxt, tick_nxt;

    always_comb begin
        slot_wrap      = (presc == PRESC_MAX);
        boundary       = slot_wrap && (idx == 2'd3);
        presc_nxt      = slot_wrap ? '0 : presc + PW'(1);
        idx_nxt        = slot_wrap ? idx + 2'd1 : idx;
        incoming       = {value_in, dp_in, en_in};
        shadow_nxt     = shadow;
        pending_nxt    = pending;
        pend_valid_nxt = pend_valid;
        // A load landing on the boundary skips the pending stage entirely.
        if (boundary) begin
            if (load)
                shadow_nxt = incoming;
            else if (pend_valid)
                shadow_nxt = pending;
            pend_valid_nxt = 1'b0;
        end else if (load) begin
            pending_nxt    = incoming;
            pend_valid_nxt = 1'b1;
        end
    end

    // Outputs look ahead to the next state so they change together with the index.
    always_comb begin
        lz[3] = (shadow_nxt.value[15:12] == 4'h0);
        lz[2] = lz[3] && (shadow_nxt.value[11:8] == 4'h0);
        lz[1] = lz[2] && (shadow_nxt.value[7:4] == 4'h0);
        lz[0] = 1'b0;
        nib_nxt  = shadow_nxt.value[{idx_nxt, 2'b00} +: 4];
        lit      = (presc_nxt >= BLANK_END) && shadow_nxt.en[idx_nxt] && !(lzb && lz[idx_nxt]);
        an_nxt   = 4'b1111;
        if (lit)
            an_nxt[idx_nxt] = 1'b0;
        dp_n_nxt = lit ? ~shadow_nxt.dp[idx_nxt] : 1'b1;
        tick_nxt = (presc_nxt == PRESC_MAX) && (idx_nxt == 2'd3);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc      <= '0;
            idx        <= '0;
            shadow     <= '0;
            pending    <= '0;
            pend_valid <= 1'b0;
            nibble_out <= 4'h0;
            an         <= 4'b1111;
            dp_n       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            presc      <= presc_nxt;
            idx        <= idx_nxt;
            shadow     <= shadow_nxt;
            pending    <= pending_nxt;
            pend_valid <= pend_valid_nxt;
            nibble_out <= nib_nxt;
            an         <= an_nxt;
            dp_n       <= dp_n_nxt;
            frame_tick <= tick_nxt;
        end
    end

endmodule
